// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched, masked, lowest-index-first interrupt controller
// Define IRQ_SYNC_EN to place a 2-flop synchroniser on every IRQ line ahead of edge detection.
module interrupt_controller #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0100,
    parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               IntEnable,
    input  logic               MaskWrite,
    input  logic [NUM_IRQ-1:0] MaskData,
    input  logic               EPCWrite,
    input  logic               InterruptDone,
    output logic               InterruptIn,
    output logic               InterruptHandler,
    output logic [2:0]         IntID,
    output logic [15:0]        IntVector,
    output logic [NUM_IRQ-1:0] Pending,
    output logic [NUM_IRQ-1:0] Mask
);
    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t             state, stateNext;
    logic [NUM_IRQ-1:0] irqSampled, irqHist, irqRise, eligible, clearMask;
    logic [2:0]         winner, intIdNext;
    logic               anyEligible, interruptInNext, handlerNext;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irqSync1, irqSync2;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            irqSync1 <= '0;
            irqSync2 <= '0;
        end else begin
            irqSync1 <= IRQ;
            irqSync2 <= irqSync1;
        end
    end

    assign irqSampled = irqSync2;
`else
    assign irqSampled = IRQ;
`endif

    assign irqRise     = irqSampled & ~irqHist;
    assign eligible    = Pending & Mask & {NUM_IRQ{IntEnable}};
    assign anyEligible = |eligible;
    assign IntVector   = VEC_BASE + 16'(IntID) * VEC_STRIDE;

    // Scan downwards so the lowest set index is the last assignment and wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    always_comb begin
        clearMask = '0;
        if (state == REQUEST && EPCWrite)
            clearMask = {{(NUM_IRQ-1){1'b0}}, 1'b1} << IntID;
    end

    // A fresh rise on the line being acknowledged must survive, so set is OR'd after clear.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            irqHist <= '0;
            Pending <= '0;
            Mask    <= '1;
        end else begin
            irqHist <= irqSampled;
            Pending <= (Pending & ~clearMask) | irqRise;
            if (MaskWrite) Mask <= MaskData;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state            <= IDLE;
            IntID            <= '0;
            InterruptIn      <= 1'b0;
            InterruptHandler <= 1'b0;
        end else begin
            state            <= stateNext;
            IntID            <= intIdNext;
            InterruptIn      <= interruptInNext;
            InterruptHandler <= handlerNext;
        end
    end

    always_comb begin
        stateNext       = state;
        intIdNext       = IntID;
        interruptInNext = InterruptIn;
        handlerNext     = InterruptHandler;
        case (state)
            IDLE: begin
                if (anyEligible) begin
                    stateNext       = REQUEST;
                    intIdNext       = winner;
                    interruptInNext = 1'b1;
                end
            end
            REQUEST: begin
                if (EPCWrite) begin
                    stateNext       = SERVICE;
                    interruptInNext = 1'b0;
                    handlerNext     = 1'b1;
                end
            end
            SERVICE: begin
                if (InterruptDone) begin
                    stateNext   = IDLE;
                    handlerNext = 1'b0;
                end
            end
            default: begin
                stateNext       = IDLE;
                interruptInNext = 1'b0;
                handlerNext     = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;
`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [3:0]  IRQ = '0;
    logic        IntEnable = 1'b0;
    logic        MaskWrite = 1'b0;
    logic [3:0]  MaskData = '0;
    logic        EPCWrite = 1'b0;
    logic        InterruptDone = 1'b0;
    logic        InterruptIn, InterruptHandler;
    logic [2:0]  IntID;
    logic [15:0] IntVector;
    logic [3:0]  Pending, Mask;

    interrupt_controller dut (
        .CLK(CLK), .CLR(CLR), .IRQ(IRQ), .IntEnable(IntEnable),
        .MaskWrite(MaskWrite), .MaskData(MaskData), .EPCWrite(EPCWrite),
        .InterruptDone(InterruptDone), .InterruptIn(InterruptIn),
        .InterruptHandler(InterruptHandler), .IntID(IntID), .IntVector(IntVector),
        .Pending(Pending), .Mask(Mask)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        intIn;
        logic        hand;
        logic [2:0]  id;
        logic [15:0] vec;
        logic [3:0]  pend;
        logic [3:0]  mask;
    } snap_t;

    snap_t      expQ[$];
    logic [2:0] reqQ[$];
    snap_t      e;
    logic [2:0] expId;
    logic       prevIn = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // Monitor: snapshot checks on request, plus every InterruptIn rise against the expected IRQ order.
    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if ({InterruptIn, InterruptHandler, IntID, IntVector, Pending, Mask} !==
                {e.intIn, e.hand, e.id, e.vec, e.pend, e.mask}) begin
                errors++;
                $display("FAIL %s: got in=%b hnd=%b id=%0d vec=%h pend=%b mask=%b want in=%b hnd=%b id=%0d vec=%h pend=%b mask=%b",
                         e.name, InterruptIn, InterruptHandler, IntID, IntVector, Pending, Mask,
                         e.intIn, e.hand, e.id, e.vec, e.pend, e.mask);
            end
        end
        if (InterruptIn === 1'b1 && prevIn !== 1'b1) begin
            checks++;
            if (reqQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_request: got id=%0d want no request", IntID);
            end else begin
                expId = reqQ.pop_front();
                if (IntID !== expId) begin
                    errors++;
                    $display("FAIL request_order: got id=%0d want id=%0d", IntID, expId);
                end
            end
        end
        prevIn = InterruptIn;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic intIn, input logic hand, input logic [2:0] id,
                       input logic [15:0] vec, input logic [3:0] pend, input logic [3:0] mask);
        snap_t s;
        s.name = name; s.intIn = intIn; s.hand = hand; s.id = id;
        s.vec = vec; s.pend = pend; s.mask = mask;
        expQ.push_back(s);
        @(negedge CLK);
        #1;
    endtask

    task automatic epc();
        EPCWrite = 1'b1;
        tick(1);
        EPCWrite = 1'b0;
    endtask

    task automatic done();
        InterruptDone = 1'b1;
        tick(1);
        InterruptDone = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        CLR = 1'b0;
        chk("reset", 0, 0, 0, 16'h0100, 4'b0000, 4'hF);

        // single request, service, return
        IntEnable = 1'b1;
        reqQ.push_back(3'd2);
        IRQ = 4'b0100;
        tick(1 + SYNC);
        chk("pend_set", 0, 0, 0, 16'h0100, 4'b0100, 4'hF);
        tick(1);
        chk("req2", 1, 0, 2, 16'h0120, 4'b0100, 4'hF);
        epc();
        chk("svc2", 0, 1, 2, 16'h0120, 4'b0000, 4'hF);
        done();
        chk("done2", 0, 0, 2, 16'h0120, 4'b0000, 4'hF);
        tick(2);
        chk("level_once", 0, 0, 2, 16'h0120, 4'b0000, 4'hF);
        IRQ = 4'b0000;
        tick(3);

        // simultaneous events: lowest index first, next one after a 1-cycle gap
        reqQ.push_back(3'd1);
        reqQ.push_back(3'd3);
        IRQ = 4'b1010;
        tick(1 + SYNC);
        chk("pend_pair", 0, 0, 2, 16'h0120, 4'b1010, 4'hF);
        tick(1);
        chk("req1", 1, 0, 1, 16'h0110, 4'b1010, 4'hF);
        epc();
        chk("svc1", 0, 1, 1, 16'h0110, 4'b1000, 4'hF);
        done();
        chk("done1", 0, 0, 1, 16'h0110, 4'b1000, 4'hF);
        tick(1);
        chk("req3", 1, 0, 3, 16'h0130, 4'b1000, 4'hF);
        epc();
        chk("svc3", 0, 1, 3, 16'h0130, 4'b0000, 4'hF);
        done();
        IRQ = 4'b0000;
        tick(3);

        // masked line accumulates; unmasking uses the old mask on the write edge
        MaskWrite = 1'b1;
        MaskData = 4'b1110;
        tick(1);
        MaskWrite = 1'b0;
        IRQ = 4'b0001;
        tick(1 + SYNC);
        chk("masked_pend", 0, 0, 3, 16'h0130, 4'b0001, 4'b1110);
        tick(2);
        chk("masked_hold", 0, 0, 3, 16'h0130, 4'b0001, 4'b1110);
        reqQ.push_back(3'd0);
        MaskWrite = 1'b1;
        MaskData = 4'hF;
        tick(1);
        MaskWrite = 1'b0;
        chk("mask_old", 0, 0, 3, 16'h0130, 4'b0001, 4'hF);
        tick(1);
        chk("req0", 1, 0, 0, 16'h0100, 4'b0001, 4'hF);
        epc();
        done();
        IRQ = 4'b0000;
        tick(3);

        // committed request, then asynchronous clear mid-service
        reqQ.push_back(3'd2);
        IRQ = 4'b0100;
        tick(2 + SYNC);
        chk("req2b", 1, 0, 2, 16'h0120, 4'b0100, 4'hF);
        IntEnable = 1'b0;
        IRQ = 4'b0101;
        tick(1 + SYNC);
        chk("committed", 1, 0, 2, 16'h0120, 4'b0101, 4'hF);
        epc();
        chk("svc2b", 0, 1, 2, 16'h0120, 4'b0001, 4'hF);
        tick(1);
        #2;
        CLR = 1'b1;
        chk("async_clr", 0, 0, 0, 16'h0100, 4'b0000, 4'hF);
        tick(1);
        CLR = 1'b0;
        IRQ = 4'b0000;
        IntEnable = 1'b1;
        tick(3);

        // new rise on the acknowledged line in the same cycle as its clear
        reqQ.push_back(3'd3);
        reqQ.push_back(3'd3);
        IRQ = 4'b1000;
        tick(2 + SYNC);
        chk("req3b", 1, 0, 3, 16'h0130, 4'b1000, 4'hF);
        IRQ = 4'b0000;
        tick(2 + SYNC);
        IRQ = 4'b1000;
        tick(SYNC);
        epc();
        chk("set_wins", 0, 1, 3, 16'h0130, 4'b1000, 4'hF);
        done();
        tick(1);
        chk("req3c", 1, 0, 3, 16'h0130, 4'b1000, 4'hF);
        IRQ = 4'b0000;
        epc();
        done();
        tick(3);

        // single-cycle pulse is captured
        reqQ.push_back(3'd1);
        IRQ = 4'b0010;
        tick(1);
        IRQ = 4'b0000;
        tick(1 + SYNC);
        chk("pulse", 1, 0, 1, 16'h0110, 4'b0010, 4'hF);
        epc();
        done();
        tick(2);

        checks++;
        if (reqQ.size() != 0) begin
            errors++;
            $display("FAIL requests_seen: got %0d outstanding want 0", reqQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream interrupt controller for the multicycle control unit.
- Latches edge-triggered external IRQ lines, masks and prioritises them, and raises InterruptIn to the control FSM.
- Takes the control unit's EPCWrite as the acceptance handshake, then holds InterruptHandler high until the handler returns.
- Supplies the handler vector address for the PC mux.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (2..8).
- VEC_BASE, 16'h0100, handler vector address for IRQ 0.
- VEC_STRIDE, 16'h0010, address spacing between consecutive vectors.

Ports:
- CLK  input  1  system clock, rising-edge active.
- CLR  input  1  asynchronous active-high reset.
- IRQ  input  NUM_IRQ  raw interrupt request lines; a rising edge is an event.
- IntEnable  input  1  global interrupt enable.
- MaskWrite  input  1  write strobe for the mask register.
- MaskData  input  NUM_IRQ  new mask value; 1 = line enabled.
- EPCWrite  input  1  from control; acknowledges the interrupt (EPC saved).
- InterruptDone  input  1  from control; handler return (reti) executed.
- InterruptIn  output  1  interrupt request to control.
- InterruptHandler  output  1  high while a handler is running.
- IntID  output  3  index of the accepted or requested IRQ.
- IntVector  output  16  equals VEC_BASE + IntID*VEC_STRIDE, truncated to 16 bits.
- Pending  output  NUM_IRQ  pending event bits.
- Mask  output  NUM_IRQ  current mask register.

Behaviour:
- Reset values (asynchronous on CLR high):
  - state = IDLE.
  - Pending = 0, Mask = all ones.
  - IntID = 0, InterruptIn = 0, InterruptHandler = 0.
  - Edge-detect history register = 0.
  - IntVector = VEC_BASE.
- Edge detection:
  - An event is recorded when IRQ[i] is sampled high at edge N and was sampled low at edge N-1.
  - The event sets Pending[i] after edge N.
  - A level held high produces one event only.
- Mask:
  - On MaskWrite at an edge, Mask <= MaskData.
  - Mask gates request generation only; masked lines still accumulate in Pending.
- Eligible set: Pending & Mask, gated by IntEnable.
- Priority: the lowest index wins.
- FSM (registered outputs):
  - IDLE: if the eligible set is nonzero, go to REQUEST, latch IntID = winning index, and set InterruptIn = 1. Earliest is one cycle after Pending sets, i.e. InterruptIn high after edge N+1.
  - REQUEST: InterruptIn stays 1 and IntID is frozen; a request is committed once raised.
    - Clearing IntEnable, clearing the Mask bit, or a higher-priority arrival does not retract or change it.
    - On EPCWrite=1: go to SERVICE, InterruptIn = 0, InterruptHandler = 1, clear Pending[IntID].
  - SERVICE: no nesting; new events only accumulate in Pending.
    - On InterruptDone=1: go to IDLE, InterruptHandler = 0.
    - Re-evaluation happens in IDLE on the next edge, so back-to-back IRQs have a minimum 1-cycle InterruptHandler-low gap.
- Ignored inputs:
  - EPCWrite in IDLE or SERVICE.
  - InterruptDone in IDLE or REQUEST.
- Simultaneous events:
  - A new rising edge on IRQ[IntID] in the same cycle as its clear: the set wins and Pending stays 1.
  - MaskWrite and a request decision in the same cycle: the decision uses the old Mask.
- IntVector is combinational from IntID.
- Reset mid-operation (CLR in REQUEST or SERVICE): the block drops to IDLE immediately and clears all pending events and the handler flag.
- Unused upper IntID bits are 0.

Optional Feature:
- IRQ_SYNC_EN defined:
  - Each IRQ line passes through a 2-flop synchroniser ahead of edge detection.
  - The event-to-Pending latency grows by 2 cycles, so InterruptIn rises after edge N+3.
  - The synchroniser flops reset to 0.
- IRQ_SYNC_EN undefined: IRQ feeds edge detection directly, with the latency given above.

Test Plan:
- Reset, then hold IRQ=0 -> Pending=0, Mask=4'hF, InterruptIn=0, IntVector=16'h0100.
- IntEnable=1, IRQ[2] rises at edge N -> Pending=4'b0100 after N; InterruptIn=1 and IntID=2 after N+1; IntVector=16'h0120. Pulse EPCWrite -> InterruptHandler=1, Pending=0. Pulse InterruptDone -> back to IDLE, InterruptHandler=0.
- IRQ[3] and IRQ[1] rise on the same edge -> IntID=1 served first. After InterruptDone, InterruptIn rises again with IntID=3 one cycle later.
- MaskData=4'b1110 with MaskWrite, then IRQ[0] rises -> Pending[0]=1, InterruptIn stays 0. Then write Mask=4'hF -> InterruptIn=1 with IntID=0.
- In REQUEST, drop IntEnable and raise IRQ[0] -> InterruptIn stays 1 and IntID unchanged. Then assert CLR mid-SERVICE -> all outputs return to their reset values asynchronously.
- With IRQ_SYNC_EN, IRQ[1] rises -> InterruptIn asserts exactly 2 cycles later than in the non-sync build. A 1-cycle IRQ pulse is still captured.
